// File: rtl/serial_add64_pkg.sv
// rtl/serial_add64_pkg.sv - shared width constant and FSM state type for serial_add64
package serial_add64_pkg;

    localparam int DATA_W = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_add64_add_chunk.sv
// rtl/serial_add64_add_chunk.sv - combinational W-bit adder slice with carry in/out
module add_chunk #(
    parameter int W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] s,
    output logic         cout
);

    assign {cout, s} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};

endmodule

// File: rtl/serial_add64.sv
// rtl/serial_add64.sv - 64-bit adder evaluated one CHUNK_W slice per cycle
// Optional signed-overflow output ovf enabled by SERIAL_ADD64_OVF_EN.
module serial_add64
    import serial_add64_pkg::*;
#(
    parameter int CHUNK_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              cin,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] s,
    output logic              cout
`ifdef SERIAL_ADD64_OVF_EN
    ,
    output logic              ovf
`endif
);

    localparam int BEATS = DATA_W / CHUNK_W;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    state_t             state;
    logic [DATA_W-1:0]  a_q;
    logic [DATA_W-1:0]  b_q;
    logic               carry_q;
    logic [CNT_W-1:0]   beat;
    logic [CHUNK_W-1:0] sum;
    logic               chunk_cout;
    logic               last;

    // Operands shift right each beat so the adder always sees the low slice.
    add_chunk #(.W(CHUNK_W)) u_add (
        .a    (a_q[CHUNK_W-1:0]),
        .b    (b_q[CHUNK_W-1:0]),
        .cin  (carry_q),
        .s    (sum),
        .cout (chunk_cout)
    );

    assign last = (beat == CNT_W'(BEATS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            carry_q   <= 1'b0;
            beat      <= '0;
            s         <= '0;
            cout      <= 1'b0;
`ifdef SERIAL_ADD64_OVF_EN
            ovf       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q      <= a;
                        b_q      <= b;
                        carry_q  <= cin;
                        beat     <= '0;
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    a_q     <= a_q >> CHUNK_W;
                    b_q     <= b_q >> CHUNK_W;
                    carry_q <= chunk_cout;
                    // Result fills from the top; after BEATS shifts slice 0 sits at bit 0.
                    s       <= {sum, s[DATA_W-1:CHUNK_W]};
                    beat    <= beat + 1'b1;
                    if (last) begin
                        cout      <= chunk_cout;
                        out_valid <= 1'b1;
                        state     <= DONE;
`ifdef SERIAL_ADD64_OVF_EN
                        // a^b^s at the MSB recovers the carry into bit 63.
                        ovf <= a_q[CHUNK_W-1] ^ b_q[CHUNK_W-1] ^ sum[CHUNK_W-1] ^ chunk_cout;
`endif
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
